// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - opcode/state encodings and datapath select constants for control_unit
package cu_pkg;

  typedef enum logic [4:0] {
    OP_HLT  = 5'h00,
    OP_STO  = 5'h01,
    OP_LD   = 5'h02,
    OP_LDI  = 5'h03,
    OP_ADD  = 5'h04,
    OP_ADDI = 5'h05,
    OP_SUB  = 5'h06,
    OP_SUBI = 5'h07,
    OP_BEQ  = 5'h08,
    OP_BNE  = 5'h09,
    OP_BGT  = 5'h0A,
    OP_BGE  = 5'h0B,
    OP_BLT  = 5'h0C,
    OP_BLE  = 5'h0D,
    OP_JMP  = 5'h0E
  } opcode_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_LATCH,
    ST_MEMRD,
    ST_EXEC,
    ST_HALT
  } state_e;

  localparam logic [1:0] SEL_A_MEM = 2'b00;
  localparam logic [1:0] SEL_A_EXT = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;
  localparam logic       ALU_ADD   = 1'b0;
  localparam logic       ALU_SUB   = 1'b1;

  // Memory-operand instructions need one extra cycle for the synchronous data RAM.
  function automatic logic needs_memrd(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/control_unit_branch_eval.sv
// rtl/control_unit_branch_eval.sv - branch condition evaluation from opcode and Z/N flags
module branch_eval
  import cu_pkg::*;
(
  input  logic [4:0] i_opcode,
  input  logic       i_flag_z,
  input  logic       i_flag_n,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_opcode)
      OP_BEQ:  o_taken = i_flag_z;
      OP_BNE:  o_taken = !i_flag_z;
      OP_BGT:  o_taken = !i_flag_z && !i_flag_n;
      OP_BGE:  o_taken = !i_flag_n;
      OP_BLT:  o_taken = i_flag_n;
      OP_BLE:  o_taken = i_flag_n || i_flag_z;
      OP_JMP:  o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle fetch/decode/execute sequencer for the accumulator datapath
module control_unit
  import cu_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int OPERAND_WIDTH = 11,
  parameter int OPCODE_WIDTH  = 5
) (
  input  logic                     clock_in,
  input  logic                     reset_n_in,
  input  logic                     enable_in,
  input  logic [DATA_WIDTH-1:0]    prog_data_in,
  input  logic                     flag_Z_in,
  input  logic                     flag_N_in,
  output logic [OPERAND_WIDTH-1:0] prog_addr_out,
  output logic [OPERAND_WIDTH-1:0] operand_out,
  output logic [1:0]               sel_A_out,
  output logic                     sel_B_out,
  output logic                     alu_op_out,
  output logic                     acc_wr_out,
  output logic                     status_wr_out,
  output logic                     acc_reset_out,
  output logic                     status_reset_out,
  output logic                     mem_wr_out,
  output logic                     halted_out
);

  state_e                   r_state;
  logic [OPERAND_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0]    r_ir;

  logic [OPCODE_WIDTH-1:0]  w_opcode;
  logic [OPCODE_WIDTH-1:0]  w_next_opcode;
  logic [OPERAND_WIDTH-1:0] w_operand;
  logic                     w_taken;

  assign w_opcode      = r_ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign w_next_opcode = prog_data_in[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign w_operand     = r_ir[OPERAND_WIDTH-1:0];

  branch_eval u_branch_eval (
    .i_opcode (w_opcode),
    .i_flag_z (flag_Z_in),
    .i_flag_n (flag_N_in),
    .o_taken  (w_taken)
  );

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state <= ST_INIT;
      r_pc    <= '0;
      r_ir    <= '0;
    end else if (enable_in) begin
      case (r_state)
        ST_INIT:  r_state <= ST_FETCH;
        ST_FETCH: r_state <= ST_LATCH;
        ST_LATCH: begin
          r_ir    <= prog_data_in;
          r_state <= needs_memrd(w_next_opcode) ? ST_MEMRD : ST_EXEC;
        end
        ST_MEMRD: r_state <= ST_EXEC;
        ST_EXEC: begin
          if (w_opcode == OP_HLT) begin
            r_state <= ST_HALT;
          end else begin
            r_pc    <= w_taken ? w_operand : r_pc + OPERAND_WIDTH'(1);
            r_state <= ST_FETCH;
          end
        end
        ST_HALT:  r_state <= ST_HALT;
        default:  r_state <= ST_INIT;
      endcase
    end
  end

  assign prog_addr_out = r_pc;
  assign operand_out   = w_operand;
  assign halted_out    = (r_state == ST_HALT);

  // Strobes are decoded from the current state and IR; a stalled unit issues none.
  always_comb begin
    sel_A_out        = SEL_A_MEM;
    sel_B_out        = 1'b0;
    alu_op_out       = ALU_ADD;
    acc_wr_out       = 1'b0;
    status_wr_out    = 1'b0;
    acc_reset_out    = 1'b0;
    status_reset_out = 1'b0;
    mem_wr_out       = 1'b0;
    if (enable_in) begin
      case (r_state)
        ST_INIT: begin
          acc_reset_out    = 1'b1;
          status_reset_out = 1'b1;
        end
        ST_EXEC: begin
          case (w_opcode)
            OP_LD: acc_wr_out = 1'b1;
            OP_LDI: begin
              sel_A_out  = SEL_A_EXT;
              acc_wr_out = 1'b1;
            end
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
              sel_A_out     = SEL_A_ALU;
              sel_B_out     = (w_opcode == OP_ADDI) || (w_opcode == OP_SUBI);
              alu_op_out    = ((w_opcode == OP_SUB) || (w_opcode == OP_SUBI)) ? ALU_SUB : ALU_ADD;
              acc_wr_out    = 1'b1;
              status_wr_out = 1'b1;
            end
            OP_STO:  mem_wr_out = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed bench for control_unit with ROM and accumulator datapath models
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [15:0] rom_q = '0;
  logic        z = 1'b0;
  logic        n = 1'b0;
  logic [10:0] prog_addr;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b, alu_op, acc_wr, status_wr, acc_reset, status_reset, mem_wr, halted;

  logic [15:0] rom  [0:2047];
  logic [15:0] dmem [0:2047];
  logic [15:0] acc = '0;
  logic [15:0] dmem_q = '0;
  logic [15:0] b_val, alu_res;

  int errors = 0;
  int checks = 0;

  control_unit dut (
    .clock_in         (clk),
    .reset_n_in       (rst_n),
    .enable_in        (en),
    .prog_data_in     (rom_q),
    .flag_Z_in        (z),
    .flag_N_in        (n),
    .prog_addr_out    (prog_addr),
    .operand_out      (operand),
    .sel_A_out        (sel_a),
    .sel_B_out        (sel_b),
    .alu_op_out       (alu_op),
    .acc_wr_out       (acc_wr),
    .status_wr_out    (status_wr),
    .acc_reset_out    (acc_reset),
    .status_reset_out (status_reset),
    .mem_wr_out       (mem_wr),
    .halted_out       (halted)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM and accumulator datapath.
  assign b_val   = sel_b ? {5'b0, operand} : dmem_q;
  assign alu_res = alu_op ? acc - b_val : acc + b_val;

  always @(posedge clk) begin
    rom_q  <= rom[prog_addr];
    dmem_q <= dmem[operand];
    if (acc_reset) acc <= '0;
    else if (acc_wr) begin
      case (sel_a)
        2'b00:   acc <= dmem_q;
        2'b01:   acc <= {5'b0, operand};
        default: acc <= alu_res;
      endcase
    end
    if (status_reset) begin
      z <= 1'b0;
      n <= 1'b0;
    end else if (status_wr) begin
      z <= (alu_res == 16'h0000);
      n <= alu_res[15];
    end
    if (mem_wr) dmem[operand] <= acc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int k);
    repeat (k) tick();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) begin
      rom[i]  = 16'h0000;
      dmem[i] = 16'h0000;
    end
  endtask

  // Leaves the DUT in its INIT cycle with enable high.
  task automatic do_reset();
    en    = 1'b1;
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int halt_cyc;
    int wr_cnt;
    logic [10:0] wr_op;

    // Reset, INIT pulse, and enable gating of the INIT clears
    clear_mem();
    en = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("init_gated_acc_reset", acc_reset, 1'b0);
    check("init_gated_status_reset", status_reset, 1'b0);
    en = 1'b1;
    #1;
    check("init_acc_reset", acc_reset, 1'b1);
    check("init_status_reset", status_reset, 1'b1);
    tick();
    check("post_init_acc_reset", acc_reset, 1'b0);
    check("post_init_addr", prog_addr, 11'h000);
    check("post_init_halted", halted, 1'b0);

    // LDI 5; ADDI 3; STO 0x010; HLT
    clear_mem();
    rom[0] = 16'h1805;
    rom[1] = 16'h2803;
    rom[2] = 16'h0810;
    rom[3] = 16'h0000;
    do_reset();
    halt_cyc = -1;
    wr_cnt = 0;
    wr_op = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (mem_wr) begin
        wr_cnt++;
        wr_op = operand;
      end
      if (halted && halt_cyc < 0) halt_cyc = c;
    end
    check("prog_halt_cycle", halt_cyc, 13);
    check("prog_wr_count", wr_cnt, 1);
    check("prog_wr_operand", wr_op, 11'h010);
    check("prog_mem_10", dmem[16], 16'h0008);
    check("prog_pc_frozen", prog_addr, 11'h003);
    check("prog_halted", halted, 1'b1);

    // LDI 2; SUBI 2; BEQ 0x020 (taken) then BNE (not taken)
    clear_mem();
    rom[0] = 16'h1802;
    rom[1] = 16'h3802;
    rom[2] = 16'h4020;
    do_reset();
    run(10);
    check("beq_target", prog_addr, 11'h020);
    rom[2] = 16'h4820;
    do_reset();
    run(10);
    check("bne_fallthrough", prog_addr, 11'h003);

    // LD 0x004: four-cycle instruction, write only in EXEC
    clear_mem();
    rom[0]  = 16'h1004;
    dmem[4] = 16'h1234;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("ld_acc_wr_c%0d", c), acc_wr, (c == 4) ? 1'b1 : 1'b0);
      if (c == 4) check("ld_sel_a", sel_a, 2'b00);
    end
    tick();
    check("ld_acc_value", acc, 16'h1234);
    check("ld_next_addr", prog_addr, 11'h001);

    // JMP 0x7FF; ROM[0x7FF] = ADDI 1 -> PC wraps to 0
    clear_mem();
    rom[0]     = 16'h77FF;
    rom[11'h7FF] = 16'h2801;
    do_reset();
    run(4);
    check("jmp_addr", prog_addr, 11'h7FF);
    run(3);
    check("wrap_addr", prog_addr, 11'h000);

    // ADD 0x005 stalled for 5 cycles in MEMRD
    clear_mem();
    rom[0]  = 16'h2005;
    dmem[5] = 16'h0007;
    do_reset();
    run(3);
    en = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall_strobes_%0d", c),
            {acc_wr, status_wr, mem_wr, acc_reset, status_reset}, 5'b00000);
      tick();
    end
    check("stall_addr", prog_addr, 11'h000);
    en = 1'b1;
    tick();
    check("stall_exec_acc_wr", acc_wr, 1'b1);
    check("stall_exec_status_wr", status_wr, 1'b1);
    check("stall_exec_sel_a", sel_a, 2'b10);
    check("stall_exec_sel_b", sel_b, 1'b0);
    tick();
    check("stall_acc_value", acc, 16'h0007);
    check("stall_next_addr", prog_addr, 11'h001);

    // LDI 9; STO 0x030 aborted by reset during EXEC
    clear_mem();
    rom[0] = 16'h1809;
    rom[1] = 16'h0830;
    do_reset();
    run(6);
    check("abort_sto_exec", mem_wr, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_wr", mem_wr, 1'b0);
    check("abort_pc", prog_addr, 11'h000);
    run(2);
    rst_n = 1'b1;
    tick();
    check("abort_refetch_addr", prog_addr, 11'h000);
    check("abort_no_write", dmem[48], 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle instruction sequencer that sits directly upstream of the accumulator datapath.
- Holds the program counter (PC) and the instruction register (IR), and fetches from a synchronous program ROM.
- Decodes a 5-bit opcode and drives the datapath selects and write enables, plus the data-memory write strobe.
- Resolves branches using the datapath's flag_Z and flag_N.

Parameters:
DATA_WIDTH, 16, instruction and data word width
OPERAND_WIDTH, 11, operand field width; also the width of the PC and the program address
OPCODE_WIDTH, 5, opcode field width (DATA_WIDTH = OPCODE_WIDTH + OPERAND_WIDTH)

Ports:
clock_in  input  1  system clock, rising edge
reset_n_in  input  1  asynchronous active-low reset
enable_in  input  1  run enable; when 0 the FSM, PC and IR hold
prog_data_in  input  DATA_WIDTH  ROM read data, valid one cycle after prog_addr_out
flag_Z_in  input  1  zero flag from the datapath
flag_N_in  input  1  negative flag from the datapath
prog_addr_out  output  OPERAND_WIDTH  ROM address (equals PC)
operand_out  output  OPERAND_WIDTH  IR[OPERAND_WIDTH-1:0], feeds the datapath operand_in
sel_A_out  output  2  datapath accumulator-source select: 00 memory, 01 ext, 10 alu
sel_B_out  output  1  datapath ALU-B select: 1 ext, 0 memory
alu_op_out  output  1  ALU operation: 0 add, 1 sub
acc_wr_out  output  1  accumulator write enable
status_wr_out  output  1  flag register write enable
acc_reset_out  output  1  synchronous clear of the accumulator
status_reset_out  output  1  synchronous clear of the flags
mem_wr_out  output  1  data-memory write strobe (data comes from datapath data_out)
halted_out  output  1  high while in HALT

Behaviour:
- Reset is asynchronous on reset_n_in low. It sets state=INIT, PC=0, IR=0.
- All control outputs are combinational from state and IR; every strobe is 0 outside the states listed below.
- Opcodes: HLT=0, STO=1, LD=2, LDI=3, ADD=4, ADDI=5, SUB=6, SUBI=7, BEQ=8, BNE=9, BGT=A, BGE=B, BLT=C, BLE=D, JMP=E. Codes 0x0F-0x1F are executed as NOP.
- State INIT: acc_reset_out=1 and status_reset_out=1 for exactly one enabled cycle, then go to FETCH.
- State FETCH: prog_addr_out=PC; go to LATCH.
- State LATCH: IR<=prog_data_in. Next state is MEMRD if the opcode in prog_data_in is LD, ADD or SUB; otherwise EXEC.
- State MEMRD: operand_out is stable and the synchronous data memory returns data next cycle; go to EXEC.
- State EXEC performs exactly one of:
  - LD: sel_A=00, acc_wr=1.
  - LDI: sel_A=01, acc_wr=1.
  - ADD/SUB: sel_B=0, sel_A=10, alu_op=0/1, acc_wr=1, status_wr=1.
  - ADDI/SUBI: same as ADD/SUB with sel_B=1.
  - STO: mem_wr=1.
  - Branches, HLT and NOP: no datapath strobes.
- PC update at the end of EXEC:
  - If a branch is taken, PC<=operand, zero-extended.
  - Otherwise PC<=PC+1, wrapping modulo 2^OPERAND_WIDTH (0x7FF -> 0x000).
  - Then go to FETCH; HLT goes to HALT instead, with the PC left unchanged.
- Branch conditions use flag values sampled in EXEC:
  - BEQ: Z; BNE: !Z; BGT: !Z&!N; BGE: !N; BLT: N; BLE: N|Z; JMP: always taken.
- HALT: halted_out=1 and all strobes 0. HALT is left only through reset.
- Latency: 3 cycles per instruction, 4 for LD/ADD/SUB, plus 1 INIT cycle after reset.
- enable_in=0 freezes state, PC and IR, and forces every strobe to 0, including INIT resets.
- The FSM resumes exactly where it stopped when enable_in returns to 1.
- Reset mid-instruction aborts it: no write is issued after reset_n_in deasserts, and the next instruction fetched is at address 0.
- Flags written by ADD/SUB in EXEC are visible to a branch in the following instruction (status is updated at the EXEC clock edge).

Decomposition:
- Package cu_pkg holds:
  - the typedef enum for opcodes (OPCODE_WIDTH bits);
  - the typedef enum for FSM states {INIT, FETCH, LATCH, MEMRD, EXEC, HALT};
  - localparams for the sel_A encodings (SEL_A_MEM=2'b00, SEL_A_EXT=2'b01, SEL_A_ALU=2'b10) and ALU_ADD/ALU_SUB.
- One natural sub-module is branch_eval: a combinational block taking opcode, flag_Z and flag_N and producing branch_taken.

Test Plan:
- Reset check: release reset -> one INIT cycle with acc_reset_out=1 and status_reset_out=1; then prog_addr_out=0x000; halted_out=0.
- Program "LDI 5; ADDI 3; STO 0x010; HLT" with a datapath model:
  - expect mem_wr_out pulsed once, with operand_out=0x010 and memory[0x10]=8;
  - expect halted_out=1 after 13 cycles (1 INIT + 4×3);
  - expect PC frozen at 3.
- Branch test: "LDI 2; SUBI 2; BEQ 0x020" -> next prog_addr_out=0x020. The same program with BNE -> next prog_addr_out=0x003.
- LD timing: "LD 0x004" -> cycle sequence FETCH, LATCH, MEMRD, EXEC; acc_wr_out=1 with sel_A_out=00 in the 4th cycle only.
- PC wrap: preload ROM[0x7FF]=ADDI 1 and jump there with "JMP 0x7FF" -> the fetch after it has prog_addr_out=0x000.
- Stall/abort test:
  - Drop enable_in for 5 cycles during MEMRD -> no strobes, state unchanged, and the instruction completes after re-enable.
  - Assert reset_n_in during EXEC of STO -> mem_wr_out=0 immediately and PC=0.
